// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared widths, source encoding and helpers for the CDB arbiter
package cdb_arbiter_pkg;

    localparam int ROB_ADDR_LEN = 4;
    localparam int DATA_LEN     = 32;
    localparam int ADDR_LEN     = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_SLB = 1'b1
    } cdb_src_e;

    // Occupancy must represent DEPTH itself, hence one bit beyond the pointer width.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer handshakes and completion broadcast of the CDB arbiter
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_W  = ROB_ADDR_LEN,
    parameter int DATA_W = DATA_LEN,
    parameter int ADDR_W = ADDR_LEN
);

    logic              alu_valid;
    logic              alu_ready;
    logic [ROB_W-1:0]  alu_robnum;
    logic [DATA_W-1:0] alu_data;
    logic              alu_need_jump;
    logic [ADDR_W-1:0] alu_true_pc;

    logic              slb_valid;
    logic              slb_ready;
    logic [ROB_W-1:0]  slb_robnum;
    logic [DATA_W-1:0] slb_data;

    logic              cdb_valid;
    logic              cdb_src;
    logic [ROB_W-1:0]  cdb_robnum;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_need_jump;
    logic [ADDR_W-1:0] cdb_true_pc;

    modport slave (
        input  alu_valid, alu_robnum, alu_data, alu_need_jump, alu_true_pc,
        output alu_ready,
        input  slb_valid, slb_robnum, slb_data,
        output slb_ready,
        output cdb_valid, cdb_src, cdb_robnum, cdb_data, cdb_need_jump, cdb_true_pc
    );

    modport master (
        output alu_valid, alu_robnum, alu_data, alu_need_jump, alu_true_pc,
        input  alu_ready,
        output slb_valid, slb_robnum, slb_data,
        input  slb_ready,
        input  cdb_valid, cdb_src, cdb_robnum, cdb_data, cdb_need_jump, cdb_true_pc
    );

endinterface

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - small power-of-two FIFO buffering one producer's completions
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin sharing of the ROB completion port between ALU and SLB
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_W      = ROB_ADDR_LEN,
    parameter int DATA_W     = DATA_LEN,
    parameter int ADDR_W     = ADDR_LEN,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         has_misbranch,
    cdb_arbiter_if.slave bus
);

    localparam int ALU_W = ROB_W + DATA_W + 1 + ADDR_W;
    localparam int SLB_W = ROB_W + DATA_W;

    logic             flush;
    logic             alu_push;
    logic             slb_push;
    logic             alu_full;
    logic             alu_empty;
    logic             slb_full;
    logic             slb_empty;
    logic [ALU_W-1:0] alu_head;
    logic [SLB_W-1:0] slb_head;
    logic             grant_alu;
    logic             grant_slb;
    cdb_src_e         last_grant;

    assign flush         = rdy && has_misbranch;
    assign bus.alu_ready = !rst && rdy && !alu_full;
    assign bus.slb_ready = !rst && rdy && !slb_full;
    // A push coinciding with a flush is dropped rather than surviving it.
    assign alu_push      = bus.alu_valid && bus.alu_ready && !has_misbranch;
    assign slb_push      = bus.slb_valid && bus.slb_ready && !has_misbranch;

    cdb_fifo #(
        .WIDTH (ALU_W),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (alu_push),
        .pop       (grant_alu),
        .flush     (flush),
        .push_data ({bus.alu_robnum, bus.alu_data, bus.alu_need_jump, bus.alu_true_pc}),
        .full      (alu_full),
        .empty     (alu_empty),
        .head      (alu_head)
    );

    cdb_fifo #(
        .WIDTH (SLB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_slb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (slb_push),
        .pop       (grant_slb),
        .flush     (flush),
        .push_data ({bus.slb_robnum, bus.slb_data}),
        .full      (slb_full),
        .empty     (slb_empty),
        .head      (slb_head)
    );

    always_comb begin
        grant_alu = 1'b0;
        grant_slb = 1'b0;
        if (rdy && !has_misbranch) begin
            if (!alu_empty && !slb_empty) begin
                if (last_grant == SRC_SLB) begin
                    grant_alu = 1'b1;
                end else begin
                    grant_slb = 1'b1;
                end
            end else if (!alu_empty) begin
                grant_alu = 1'b1;
            end else if (!slb_empty) begin
                grant_slb = 1'b1;
            end
        end
    end

    // Payload registers hold on idle cycles; only cdb_valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cdb_valid     <= 1'b0;
            bus.cdb_src       <= SRC_ALU;
            bus.cdb_robnum    <= '0;
            bus.cdb_data      <= '0;
            bus.cdb_need_jump <= 1'b0;
            bus.cdb_true_pc   <= '0;
            last_grant        <= SRC_SLB;
        end else if (rdy) begin
            if (has_misbranch) begin
                bus.cdb_valid <= 1'b0;
            end else if (grant_alu) begin
                bus.cdb_valid     <= 1'b1;
                bus.cdb_src       <= SRC_ALU;
                bus.cdb_robnum    <= alu_head[ALU_W-1 -: ROB_W];
                bus.cdb_data      <= alu_head[ADDR_W+1 +: DATA_W];
                bus.cdb_need_jump <= alu_head[ADDR_W];
                bus.cdb_true_pc   <= alu_head[ADDR_W-1:0];
                last_grant        <= SRC_ALU;
            end else if (grant_slb) begin
                bus.cdb_valid     <= 1'b1;
                bus.cdb_src       <= SRC_SLB;
                bus.cdb_robnum    <= slb_head[SLB_W-1 -: ROB_W];
                bus.cdb_data      <= slb_head[DATA_W-1:0];
                bus.cdb_need_jump <= 1'b0;
                bus.cdb_true_pc   <= '0;
                last_grant        <= SRC_SLB;
            end else begin
                bus.cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the ROB's single completion-write port between the ALU and the store/load buffer. Each producer pushes results through a valid/ready handshake into its own small FIFO. The arbiter round-robins between the non-empty FIFOs and drives one registered completion broadcast per cycle to the ROB. It sits between the execution units and the ROB and is flushed on misbranch.

Parameters:
ROB_W, 4, ROB index width (matches `Rob_Addr_Len).
DATA_W, 32, result data width (matches `Data_Len).
ADDR_W, 32, PC width (matches `Addr_Len).
FIFO_DEPTH, 2, entries per source FIFO; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; asynchronous, active-high
rdy  in  1  global ready; when low, all state holds
has_misbranch  in  1  flush from ROB
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU FIFO can accept
alu_robnum  in  ROB_W  ROB entry of the ALU result
alu_data  in  DATA_W  ALU result value
alu_need_jump  in  1  branch/jalr resolved as taken
alu_true_pc  in  ADDR_W  resolved target PC
slb_valid  in  1  SLB result valid
slb_ready  out  1  SLB FIFO can accept
slb_robnum  in  ROB_W  ROB entry of the SLB result
slb_data  in  DATA_W  load value (don't-care for stores)
cdb_valid  out  1  broadcast valid, one cycle per entry
cdb_src  out  1  0 = ALU, 1 = SLB
cdb_robnum  out  ROB_W  broadcast ROB entry
cdb_data  out  DATA_W  broadcast value
cdb_need_jump  out  1  taken flag; 0 when cdb_src = 1
cdb_true_pc  out  ADDR_W  target PC; 0 when cdb_src = 1

Behaviour:
- Reset (asynchronous, rst high):
  - Both FIFOs emptied (pointers 0, counts 0).
  - cdb_valid = 0; cdb_src, cdb_robnum, cdb_data, cdb_need_jump, cdb_true_pc = 0.
  - last_grant = SLB, so the ALU wins the first tie.
  - alu_ready and slb_ready are forced low while rst is high.
- Ready outputs are combinational: x_ready = !rst && rdy && (count_x < FIFO_DEPTH).
  - No pop-through: a full FIFO stays not-ready even in a cycle where it pops.
- Push: occurs on an edge where x_valid && x_ready. The producer holds valid and payload stable until accepted.
- Occupancy and pointers:
  - Count width is log2(FIFO_DEPTH)+1.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop on one FIFO leaves the count unchanged.
- Grant, evaluated on each edge with rdy high and no flush:
  - Neither FIFO non-empty → no grant.
  - Exactly one non-empty → grant it.
  - Both non-empty → grant the source != last_grant.
  - On a grant: pop the head, register it onto the cdb_* outputs, set cdb_valid = 1, set last_grant.
- No grant: cdb_valid = 0 next cycle; the payload outputs hold their last values.
- Latency: an entry pushed at edge k appears on cdb_* after edge k+1 at the earliest. There is no input-to-output bypass.
- Throughput: one broadcast per cycle. With both FIFOs continuously non-empty, grants strictly alternate, so worst-case wait is 1 cycle per head.
- Flush (has_misbranch high at an edge with rdy high):
  - Both FIFOs emptied and cdb_valid = 0.
  - Pushes in that same cycle are dropped.
  - last_grant is retained.
  - Flush has priority over push and grant.
- rdy low:
  - No push (ready outputs low), no pop, no grant.
  - cdb_* and cdb_valid hold their registered values.
  - A flush is ignored until rdy returns high.
- Reset asserted mid-operation clears everything immediately, regardless of rdy.
- SLB entries drive cdb_need_jump = 0 and cdb_true_pc = 0.

Decomposition:
- Shared constants come from config.v: `Rob_Addr_Len, `Data_Len, `Addr_Len, `True, `False.
- Add `Src_Alu = 1'b0 and `Src_Slb = 1'b1 there.
- One sub-module, cdb_fifo, parameterised by WIDTH and DEPTH:
  - Ports: push/pop/flush, full/empty, head data.
  - Instanced twice: ALU width ROB_W+DATA_W+1+ADDR_W, SLB width ROB_W+DATA_W.
- Arbitration, last_grant and output registers live in cdb_arbiter.

Test Plan:
1. Async reset: assert rst between edges while cdb_valid = 1 → cdb_valid = 0 without waiting for an edge; alu_ready = slb_ready = 0 during rst; both = 1 once rst is low and rdy = 1.
2. Single ALU push, robnum 3, data 0x11, need_jump 1, true_pc 0x1004, at edge k → after edge k+1: cdb_valid = 1, src = 0, robnum 3, data 0x11, need_jump 1, true_pc 0x1004; cdb_valid = 0 after edge k+2.
3. Tie after reset: ALU robnum 1 and SLB robnum 2 pushed on the same edge → broadcasts are ALU/1, then SLB/2 on consecutive cycles, then idle.
4. Saturation with FIFO_DEPTH = 2: both sources hold valid for 6 cycles → broadcasts strictly alternate; x_ready drops when count = 2; no entry is lost or duplicated; order within each source is preserved.
5. Flush: both FIFOs full, has_misbranch pulsed with alu_valid high → next cycle cdb_valid = 0, both counts 0, the concurrent push is dropped; a later SLB push of robnum 7 broadcasts normally.
6. Stall: with an entry on cdb_* and one queued, drop rdy for 3 cycles → outputs frozen and ready outputs low; the queued entry broadcasts one edge after rdy returns high.
